hansen_mem_arbiter: RTL

Two-port arbiter that shares one single-port synchronous block RAM between the Hansen core's instruction-fetch port and data port. It sits between `hansen_core` and the FPGA BRAM in the unified-memory SoC, replacing direct dual reads with a valid/grant handshake. Every cycle it grants at most one access, drives the BRAM, returns read data one cycle later with the requester's valid, flags out-of-range addresses, and counts conflict stalls.

---
 rtl/hansen_pkg.sv | 6 +
 rtl/hansen_rr_arb2.sv | 43 ++++
 rtl/hansen_mem_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/hansen_pkg.sv
// Shared constants for the Hansen memory arbiter: port encodings and counter limit.
package hansen_pkg;
    localparam logic        HANSEN_PORT_I    = 1'b0;
    localparam logic        HANSEN_PORT_D    = 1'b1;
    localparam logic [15:0] HANSEN_STALL_MAX = 16'hFFFF;
endpackage

// File: rtl/hansen_rr_arb2.sv
// Two-request grant logic. HANSEN_ARB_RR_EN selects round-robin on ties,
// otherwise fixed priority D over I with no state.
module hansen_rr_arb2
    import hansen_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic tie_pick;

`ifdef HANSEN_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the port that did not win last time goes first.
    assign tie_pick = ~last_q;

    always_comb begin
        last_d = last_q;
        if (gnt_o[HANSEN_PORT_D])      last_d = HANSEN_PORT_D;
        else if (gnt_o[HANSEN_PORT_I]) last_d = HANSEN_PORT_I;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= HANSEN_PORT_D;
        else          last_q <= last_d;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign tie_pick       = HANSEN_PORT_D;
`endif

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (&req_i) gnt_o[tie_pick] = 1'b1;
            else        gnt_o = req_i;
        end
    end
endmodule

// File: rtl/hansen_mem_arbiter.sv
// Shares one single-port BRAM between the fetch (I) and data (D) ports.
// Define HANSEN_ARB_RR_EN for round-robin ties; default is fixed D-over-I priority.
module hansen_mem_arbiter
    import hansen_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   stall_cnt
);
    logic [1:0]  gnt;
    logic        i_inr, d_inr;
    logic        rsel_q, rvalid_q, err_q;
    logic        rsel_d, rvalid_d, err_d;
    logic [15:0] stall_q, stall_d;
    logic        unused_lsb;

    assign unused_lsb = ^{i_addr[1:0], d_addr[1:0]};

    hansen_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (reset_n),
        .req_i   ({d_req, i_req}),
        .gnt_o   (gnt)
    );

    assign i_gnt = gnt[HANSEN_PORT_I];
    assign d_gnt = gnt[HANSEN_PORT_D];
    assign i_inr = (i_addr[31:AW+2] == '0);
    assign d_inr = (d_addr[31:AW+2] == '0);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = d_inr;
            mem_we    = (d_inr && d_we) ? d_be : 4'b0000;
            mem_addr  = d_addr[AW+1:2];
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_en    = i_inr;
            mem_addr  = i_addr[AW+1:2];
        end
    end

    // Reads always respond; writes respond only when dropped as out of range.
    always_comb begin
        rsel_d   = d_gnt ? HANSEN_PORT_D : HANSEN_PORT_I;
        rvalid_d = i_gnt | (d_gnt & (~d_we | ~d_inr));
        err_d    = (i_gnt & ~i_inr) | (d_gnt & ~d_inr);
        stall_d  = stall_q;
        if (((i_req & ~i_gnt) | (d_req & ~d_gnt)) && stall_q != HANSEN_STALL_MAX)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsel_q   <= HANSEN_PORT_I;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            rsel_q   <= rsel_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
        end
    end

    assign i_rvalid  = rvalid_q & (rsel_q == HANSEN_PORT_I);
    assign d_rvalid  = rvalid_q & (rsel_q == HANSEN_PORT_D);
    assign i_err     = i_rvalid & err_q;
    assign d_err     = d_rvalid & err_q;
    assign i_rdata   = (i_rvalid && !err_q) ? mem_rdata : 32'h0;
    assign d_rdata   = (d_rvalid && !err_q) ? mem_rdata : 32'h0;
    assign stall_cnt = stall_q;
endmodule
